// File: rtl/ex_muldiv_pkg.sv
// Op codes, widths, FSM encoding and op-class helpers for the RV32M execute unit.
package ex_muldiv_pkg;

  localparam int OP_LEN       = 5;
  localparam int REG_LEN      = 32;
  localparam int REG_ADDR_LEN = 5;

  localparam logic [OP_LEN-1:0] OP_MUL    = 5'h10;
  localparam logic [OP_LEN-1:0] OP_MULH   = 5'h11;
  localparam logic [OP_LEN-1:0] OP_MULHSU = 5'h12;
  localparam logic [OP_LEN-1:0] OP_MULHU  = 5'h13;
  localparam logic [OP_LEN-1:0] OP_DIV    = 5'h14;
  localparam logic [OP_LEN-1:0] OP_DIVU   = 5'h15;
  localparam logic [OP_LEN-1:0] OP_REM    = 5'h16;
  localparam logic [OP_LEN-1:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic op_is_m(input logic [OP_LEN-1:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic op_is_mul(input logic [OP_LEN-1:0] op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic op_is_rem(input logic [OP_LEN-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_div_signed(input logic [OP_LEN-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_a_signed(input logic [OP_LEN-1:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic op_b_signed(input logic [OP_LEN-1:0] op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Unsigned restoring divider on magnitudes, one quotient bit per enabled step.
// Latency: XLEN steps after start; done marks the final step, quo/rem carry that step's result.
// Backpressure: en=0 freezes all state.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);
  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo_r, rem_r, dsr_r;
  logic [XLEN:0]   trial, diff;

  // quo_r shifts the dividend out at the top while quotient bits enter at the bottom
  assign trial = {rem_r, quo_r[XLEN-1]};
  assign diff  = trial - {1'b0, dsr_r};
  assign quo   = {quo_r[XLEN-2:0], ~diff[XLEN]};
  assign rem   = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
  assign done  = (cnt == CW'(XLEN-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
      dsr_r <= '0;
    end else if (en) begin
      if (start) begin
        quo_r <= dividend;
        rem_r <= '0;
        dsr_r <= divisor;
        cnt   <= '0;
      end else if (step) begin
        quo_r <= quo;
        rem_r <= rem;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M execute unit: 2-cycle multiply, iterative divide, result pulse toward EX/MEM.
// Latency: MUL 2 cycles, DIV 33 cycles, divide-by-zero/overflow 1 cycle from accept.
// Backpressure: stall_req holds ID/EX while busy; rdy=0 freezes everything; flush aborts.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = REG_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [OP_LEN-1:0]       in_op,
  input  logic [XLEN-1:0]         in_reg1,
  input  logic [XLEN-1:0]         in_reg2,
  input  logic [REG_ADDR_LEN-1:0] in_rd,
  output logic                    stall_req,
  output logic                    out_valid,
  output logic [REG_ADDR_LEN-1:0] out_rd,
  output logic [XLEN-1:0]         out_data
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t                  state;
  logic [OP_LEN-1:0]       op_q;
  logic [XLEN-1:0]         a_q, b_q;
  logic [REG_ADDR_LEN-1:0] rd_q;
  logic                    q_neg, r_neg;

  logic            want, accept;
  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign want      = (state == S_IDLE) && in_valid && op_is_m(in_op) && !flush;
  assign accept    = want && rdy;
  assign stall_req = want || (!flush && ((state == S_MUL) || (state == S_DIV)));

  assign a_neg       = op_div_signed(in_op) && in_reg1[XLEN-1];
  assign b_neg       = op_div_signed(in_op) && in_reg2[XLEN-1];
  assign mag_a       = a_neg ? -in_reg1 : in_reg1;
  assign mag_b       = b_neg ? -in_reg2 : in_reg2;
  assign div_zero    = (in_reg2 == '0);
  assign div_ovf     = op_div_signed(in_op) && (in_reg1 == MIN_NEG) && (in_reg2 == '1);
  assign special_res = div_zero ? (op_is_rem(in_op) ? in_reg1 : '1)
                                : (op_is_rem(in_op) ? '0 : MIN_NEG);

  // 33-bit sign/zero extension carried to 2*XLEN; only the low 2*XLEN product bits matter
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_a   = {{XLEN{op_a_signed(op_q) && a_q[XLEN-1]}}, a_q};
  assign mul_b   = {{XLEN{op_b_signed(op_q) && b_q[XLEN-1]}}, b_q};
  assign prod    = mul_a * mul_b;
  assign mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  logic            div_start, div_step, div_done;
  logic [XLEN-1:0] div_quo, div_rem, div_res;

  assign div_start = accept && !op_is_mul(in_op);
  assign div_step  = (state == S_DIV) && !flush;
  assign div_res   = op_is_rem(op_q) ? (r_neg ? -div_rem : div_rem)
                                     : (q_neg ? -div_quo : div_quo);

  div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy),
    .start    (div_start),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_data  <= '0;
    end else if (rdy) begin
      out_valid <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: if (accept) begin
            op_q  <= in_op;
            a_q   <= in_reg1;
            b_q   <= in_reg2;
            rd_q  <= in_rd;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            if (op_is_mul(in_op)) begin
              state <= S_MUL;
            end else if (div_zero || div_ovf) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              out_data  <= special_res;
              out_rd    <= in_rd;
            end else begin
              state <= S_DIV;
            end
          end
          S_MUL: begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_data  <= mul_res;
            out_rd    <= rd_q;
          end
          S_DIV: if (div_done) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_data  <= div_res;
            out_rd    <= rd_q;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid;
  logic [4:0]  in_op;
  logic [31:0] in_reg1, in_reg2;
  logic [4:0]  in_rd;
  logic        stall_req, out_valid;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_valid(in_valid),
    .in_op(in_op), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_rd(in_rd),
    .stall_req(stall_req), .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // expected in-flight result: pending from the accept cycle until its out_valid cycle
  bit          pending = 0;
  bit          chk_en  = 0;
  int          acc_cyc, exp_cyc, lat_seen;
  logic [31:0] exp_data, last_data;
  logic [4:0]  exp_rd;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit is_m(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    up  = 0;
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      OP_MULHU:  begin up = ua * ub; return up[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      OP_DIVU:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      OP_REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      OP_REMU:   begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
      default:   return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op <= OP_MULHU) return 2;
    if (b == 0) return 1;
    if (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
      return 1;
    return 33;
  endfunction

  // per-cycle compare, sampled on the falling edge
  always @(negedge clk) begin
    bit busy_exp, vld_exp;
    if (rst && chk_en) begin
      busy_exp = pending && (cyc < exp_cyc);
      vld_exp  = pending && (cyc == exp_cyc);
      chk("stall_req", stall_req, busy_exp && !flush);
      chk("out_valid", out_valid, vld_exp);
      if (vld_exp) begin
        chk("out_data", out_data, exp_data);
        chk("out_rd", out_rd, exp_rd);
        last_data = out_data;
        lat_seen  = cyc - acc_cyc;
        if (rdy) pending = 0;
        else exp_cyc++;
      end else if (busy_exp && flush && rdy) begin
        pending = 0;
      end else if (busy_exp && !rdy && (cyc > acc_cyc)) begin
        exp_cyc++;
      end
    end
  end

  // called at posedge+1; returns at posedge+1 of the cycle after the pulse
  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_reg1  = a;
    in_reg2  = b;
    in_rd    = rd;
    if (is_m(op)) begin
      exp_data = ref_res(op, a, b);
      exp_rd   = rd;
      acc_cyc  = cyc;
      exp_cyc  = cyc + ref_lat(op, a, b);
      pending  = 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_reg1  = $urandom();
    in_reg2  = $urandom();
    in_rd    = 5'($urandom());
  endtask

  task automatic wait_done(input bit jit);
    int g = 0;
    while (pending && (g < 200)) begin
      @(posedge clk); #1;
      if (jit) rdy = ($urandom_range(0, 5) != 0);
      g++;
    end
    rdy = 1'b1;
    if (pending) begin
      checks++;
      errors++;
      $display("FAIL timeout cyc=%0d got no out_valid want out_valid", cyc);
      pending = 0;
    end
  endtask

  task automatic run_dir(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input logic [4:0] rd);
    chk("model", ref_res(op, a, b), res);
    lat_seen  = -1;
    last_data = ~res;
    start_op(op, a, b, rd);
    wait_done(1'b0);
    chk("latency", lat_seen, lat);
    chk("result", last_data, res);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op_tab [9];
    op_tab = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, 5'h03};
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_op = '0; in_reg1 = '0; in_reg2 = '0; in_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_stall", stall_req, 0);
    rst = 1'b1;
    chk_en = 1;
    @(posedge clk); #1;

    run_dir(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2,  1);
    run_dir(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2,  2);
    run_dir(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         2,  3);
    run_dir(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2,  4);
    run_dir(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 5);
    run_dir(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 6);
    run_dir(OP_DIVU,   32'd100,       32'd7,         32'd14,        33, 7);
    run_dir(OP_REMU,   32'd100,       32'd7,         32'd2,         33, 0);
    run_dir(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,  8);
    run_dir(OP_REM,    32'd5,         32'd0,         32'd5,         1,  9);
    run_dir(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  10);
    run_dir(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  11);

    // flush at divide iteration 10, then a normal multiply
    start_op(OP_DIV, 32'd1000, 32'd7, 5'd12);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    chk("flush_stall", stall_req, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    run_dir(OP_MUL, 32'd3, 32'd4, 32'd12, 2, 13);

    // rdy low for 5 cycles mid-divide
    lat_seen = -1;
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd14);
    repeat (5) begin @(posedge clk); #1; end
    rdy = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rdy = 1'b1;
    wait_done(1'b0);
    chk("rdy_latency", lat_seen, 38);
    chk("rdy_result", last_data, 32'hFFFF_FFFD);

    // reset mid-divide
    run_dir(OP_MUL, 32'd5, 32'd6, 32'd30, 2, 15);
    start_op(OP_DIV, 32'd100, 32'd7, 5'd16);
    repeat (8) begin @(posedge clk); #1; end
    chk_en = 0;
    pending = 0;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_rd", out_rd, 0);
    chk("midrst_stall", stall_req, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1;
    @(posedge clk); #1;
    run_dir(OP_MUL, 32'd3, 32'd4, 32'd12, 2, 17);

    for (int n = 0; n < 150; n++) begin
      start_op(op_tab[$urandom_range(0, 8)], pick(), pick(), 5'($urandom()));
      wait_done(1'b1);
    end
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
